// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers for the MIPS Execute stage.
// Results are computed at issue, held as pending, and committed after a fixed latency.
module mult_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, mag_q, mag_r;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] result;

  // Sign-extending before a 2W-bit multiply gives the correct signed product modulo 2^(2W).
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    a_ext     = is_signed ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    b_ext     = is_signed ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    prod      = a_ext * b_ext;
    acc       = {hi_q, lo_q};
  end

  // Signed divide runs on magnitudes; MIN / -1 falls out as quotient MIN, remainder 0.
  always_comb begin
    a_neg = is_signed & rs[WIDTH-1];
    b_neg = is_signed & rt[WIDTH-1];
    abs_a = a_neg ? -rs : rs;
    abs_b = b_neg ? -rt : rt;
    mag_q = '1;
    mag_r = abs_a;
    if (rt != '0) begin
      mag_q = abs_a / abs_b;
      mag_r = abs_a % abs_b;
    end
    quo = (a_neg ^ b_neg) ? -mag_q : mag_q;
    rem = a_neg ? -mag_r : mag_r;
    if (rt == '0) begin
      quo = '1;
      rem = rs;
    end
  end

  always_comb begin
    result = prod;
    case (op)
      OP_MADD, OP_MADDU: result = acc + prod;
      OP_MSUB, OP_MSUBU: result = acc - prod;
      OP_DIV, OP_DIVU:   result = {rem, quo};
      default:           result = prod;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              {pend_hi_d, pend_lo_d} = result;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              {pend_hi_d, pend_lo_d} = result;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed boundary scenarios plus random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int checks;
  int errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .rs(rs),
    .rt(rt),
    .cancel(cancel),
    .busy(busy),
    .hi(hi),
    .lo(lo),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {hi, lo} after the op, using plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    int          q;
    int          r;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    case (o)
      4'd1: return sp;
      4'd2: return up;
      4'd5: return {h, l} + sp;
      4'd6: return {h, l} + up;
      4'd7: return {h, l} - sp;
      4'd8: return {h, l} - up;
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {h, l};
    endcase
  endfunction

  function automatic int latency(input logic [3:0] o);
    return (o == 4'd3 || o == 4'd4) ? 10 : 5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a timed op and follows it to the done cycle (left there for back-to-back issue).
  task automatic exec_timed(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    int          lat;
    res    = ref_result(o, a, b, exp_hi, exp_lo);
    lat    = latency(o);
    start  = 1'b1;
    op     = o;
    rs     = a;
    rt     = b;
    step();
    start  = 1'b0;
    op     = 4'd0;
    rs     = $urandom;
    rt     = $urandom;
    for (int i = 0; i < lat; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL exec_busy op=%0d cyc=%0d: busy=%b done=%b hi=%h lo=%h, want busy=1 done=0 hi=%h lo=%h",
                 o, i + 1, busy, done, hi, lo, exp_hi, exp_lo);
      end
      step();
    end
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL exec_commit op=%0d a=%h b=%h: busy=%b done=%b hi=%h lo=%h, want busy=0 done=1 hi=%h lo=%h",
               o, a, b, busy, done, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic do_move(input logic [3:0] o, input logic [31:0] v, input logic cx);
    start  = 1'b1;
    op     = o;
    rs     = v;
    cancel = cx;
    step();
    start  = 1'b0;
    cancel = 1'b0;
    op     = 4'd0;
    if (!cx) begin
      if (o == 4'd9) exp_hi = v;
      else           exp_lo = v;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL move op=%0d cancel=%b: busy=%b done=%b hi=%h lo=%h, want busy=0 done=0 hi=%h lo=%h",
               o, cx, busy, done, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 4'd0;
    rs     = '0;
    rt     = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_init: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    step();
    step();
    reset  = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    step();
    do_move(4'd9, 32'hDEAD_BEEF, 1'b0);
    do_move(4'd10, 32'hCAFE_F00D, 1'b0);
    start = 1'b1;
    op    = 4'd3;
    rs    = 32'd100;
    rt    = 32'd7;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_div: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        errors++;
        $display("FAIL reset_no_commit cyc=%0d: busy=%b done=%b hi=%h lo=%h, want all zero",
                 i, busy, done, hi, lo);
      end
    end
  endtask

  task automatic test_mult();
    do_move(4'd9, 32'hAAAA_5555, 1'b0);
    do_move(4'd10, 32'h1234_ABCD, 1'b0);
    exec_timed(4'd1, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_signed: hi=%h lo=%h, want hi=ffffffff lo=fffffffa", hi, lo);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mult_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_multu_maddu();
    exec_timed(4'd2, 32'hFFFF_FFFF, 32'd2);
    checks++;
    if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu: hi=%h lo=%h, want hi=1 lo=fffffffe", hi, lo);
    end
    exec_timed(4'd6, 32'd1, 32'd2);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd0) begin
      errors++;
      $display("FAIL maddu: hi=%h lo=%h, want hi=2 lo=0", hi, lo);
    end
    step();
  endtask

  task automatic test_div();
    exec_timed(4'd3, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg: hi=%h lo=%h, want hi=ffffffff lo=fffffffd", hi, lo);
    end
    step();
    exec_timed(4'd4, 32'd5, 32'd0);
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
      errors++;
      $display("FAIL divu_zero: hi=%h lo=%h, want hi=5 lo=ffffffff", hi, lo);
    end
    step();
    exec_timed(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++;
      $display("FAIL div_min_m1: hi=%h lo=%h, want hi=0 lo=80000000", hi, lo);
    end
    step();
    exec_timed(4'd3, 32'd9, 32'd0);
    step();
  endtask

  task automatic test_cancel();
    do_move(4'd9, 32'h0BAD_CAFE, 1'b0);
    do_move(4'd10, 32'h7777_1111, 1'b0);
    start = 1'b1;
    op    = 4'd1;
    rs    = 32'd123;
    rt    = 32'd456;
    step();
    start = 1'b0;
    step();
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL cancel_run: busy=%b done=%b hi=%h lo=%h, want busy=0 done=0 hi=%h lo=%h",
               busy, done, hi, lo, exp_hi, exp_lo);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL cancel_after cyc=%0d: done=%b hi=%h lo=%h, want done=0 hi=%h lo=%h",
                 i, done, hi, lo, exp_hi, exp_lo);
      end
    end
    // Cancel on the commit edge must win.
    start = 1'b1;
    op    = 4'd2;
    rs    = 32'hFFFF_0000;
    rt    = 32'h0001_0003;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL cancel_commit: busy=%b done=%b hi=%h lo=%h, want busy=0 done=0 hi=%h lo=%h",
               busy, done, hi, lo, exp_hi, exp_lo);
    end
    step();
    do_move(4'd10, 32'h5A5A_5A5A, 1'b1);
    do_move(4'd9, 32'hA5A5_A5A5, 1'b1);
  endtask

  task automatic test_ignore();
    logic [63:0] res;
    res   = ref_result(4'd1, 32'hFFFF_FFF0, 32'd16, exp_hi, exp_lo);
    start = 1'b1;
    op    = 4'd1;
    rs    = 32'hFFFF_FFF0;
    rt    = 32'd16;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    op    = 4'd3;
    rs    = 32'd1000;
    rt    = 32'd3;
    step();
    start = 1'b0;
    op    = 4'd0;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL ignore_busy: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h", busy, hi, lo, exp_hi, exp_lo);
    end
    step();
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL ignore_commit: busy=%b done=%b hi=%h lo=%h, want busy=0 done=1 hi=%h lo=%h",
               busy, done, hi, lo, exp_hi, exp_lo);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL ignore_after cyc=%0d: busy=%b done=%b hi=%h lo=%h, want idle hi=%h lo=%h",
                 i, busy, done, hi, lo, exp_hi, exp_lo);
      end
    end
    do_move(4'd9, 32'h1234_5678, 1'b0);
    start = 1'b1;
    op    = 4'd13;
    rs    = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL op_none: busy=%b done=%b hi=%h lo=%h, want busy=0 done=0 hi=%h lo=%h",
               busy, done, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_back_to_back();
    exec_timed(4'd1, 32'd7, 32'hFFFF_FFFD);
    exec_timed(4'd1, 32'h0001_0000, 32'h0001_0000);
    exec_timed(4'd7, 32'd3, 32'd5);
    step();
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 40; n++) begin
      o = 4'($urandom_range(1, 10));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(1, 9));
      if (o == 4'd9 || o == 4'd10) do_move(o, a, 1'($urandom_range(0, 1)));
      else exec_timed(o, a, b);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_hi = '0;
    exp_lo = '0;
    test_reset();
    test_mult();
    test_multu_maddu();
    test_div();
    test_cancel();
    test_ignore();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the MIPS Execute stage.
- Successor to the fixed 32-bit, fixed-latency multiply/divide unit.
- Adds configurable width and latencies, MADD/MSUB accumulate ops, a cancel input for exception flush, and a done pulse.
- Takes an already-decoded op from the Execute-stage controller; HI/LO feed the mfhi/mflo forwarding path.

Parameters:
WIDTH, 32, operand and HI/LO width (>=2)
MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  issue strobe; op is valid this cycle
op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; 11-15 treated as NONE
rs  input  WIDTH  operand A; also the MTHI/MTLO source
rt  input  WIDTH  operand B
cancel  input  1  flush: abort an in-flight op, block a same-cycle issue
busy  output  1  operation in flight; Execute stage stalls md instructions while busy|start
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
done  output  1  one-cycle pulse after a successful HI/LO commit from a timed op

Behaviour:
- States: IDLE and RUN. Down-counter cnt, width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, done=0, state IDLE, pending results discarded. This applies mid-operation too.
- IDLE, start=1, cancel=0, timed op (1-8):
  - Capture the result into pending_hi/pending_lo at this edge.
  - Load cnt = latency; state goes to RUN; busy=1 from the next cycle.
- Result arithmetic, computed from operand and HI/LO values at the issue edge:
  - MULT: signed WIDTH x WIDTH to 2*WIDTH; {hi,lo} = product.
  - MULTU: same, unsigned.
  - MADD/MADDU: {hi,lo} + product, modulo 2^(2*WIDTH).
  - MSUB/MSUBU: {hi,lo} - product, modulo 2^(2*WIDTH).
  - DIV/DIVU: lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
- Divide boundaries:
  - rt==0: lo = all ones, hi = rs.
  - Signed MIN / -1: lo = MIN, hi = 0.
- RUN:
  - cnt decrements each edge.
  - At the edge where cnt==1: hi/lo <- pending, state goes to IDLE, busy=0 and done=1 in the following cycle.
  - Net effect: busy is high for exactly latency cycles; new HI/LO are visible in the first cycle busy is low.
- hi/lo keep their old values for the whole time busy is high; no partial results are ever visible.
- MTHI/MTLO with start=1, cancel=0, IDLE: hi (or lo) <- rs at the edge. No busy, no done.
- start=1 during RUN: ignored; no effect on the in-flight op.
- cancel=1 during RUN: abort at the edge; state goes to IDLE, busy=0 next cycle, hi/lo unchanged, no done.
- cancel=1 and start=1 in IDLE: issue suppressed, including MTHI/MTLO.
- cancel=1 on the commit edge (cnt==1): cancel wins; no commit.
- done is registered and high for exactly one cycle. A new start is accepted in the same cycle done is high.
- op NONE, or start=0: no state change.

Test Plan:
- Reset: drive reset=0 mid-DIV (cycle 4 of 10), release -> hi=0, lo=0, busy=0, done=0, and no later commit.
- Signed MULT: rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; hi/lo unchanged during busy; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- MULTU then MADDU: MULTU rs=0xFFFFFFFF, rt=2 -> hi=1, lo=0xFFFFFFFE; MADDU rs=1, rt=2 -> hi=2, lo=0.
- DIV boundaries:
  - DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, after exactly 10 busy cycles.
  - DIVU rt=0, rs=5 -> lo=0xFFFFFFFF, hi=5.
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Cancel:
  - cancel at busy cycle 3 of a MULT -> busy low next cycle; hi/lo keep pre-issue values; done stays 0.
  - cancel together with MTLO start -> lo unchanged.
- Issue and ignore rules:
  - start of DIV during a running MULT -> ignored; only the MULT result commits, at cycle 5.
  - MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0.
  - Back-to-back MULT issued in the done cycle -> accepted.
